// File: rtl/muldiv_pkg.sv
// muldiv_pkg: function codes, ALUOp class and FSM encoding shared by the muldiv unit
package muldiv_pkg;
   localparam logic [5:0] MULTU = 6'b011001;
   localparam logic [5:0] DIVU = 6'b011011;
   localparam logic [5:0] MFHI = 6'b010000;
   localparam logic [5:0] MFLO = 6'b010010;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;
   typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one shift-add multiply or restoring divide iteration over {acc, low}
module muldiv_step import muldiv_pkg::*; #(
   parameter int WIDTH = 32
) (
   input  state_t           mode,
   input  logic [WIDTH:0]   acc,
   input  logic [WIDTH-1:0] low,
   input  logic [WIDTH-1:0] opnd,
   output logic [WIDTH:0]   acc_n,
   output logic [WIDTH-1:0] low_n
);
   logic [WIDTH:0] sum;
   logic [WIDTH+1:0] sh, trial;
   always_comb begin
      sum = acc + {1'b0, low[0] ? opnd : {WIDTH{1'b0}}};
      sh = {acc, low[WIDTH-1]};
      trial = sh - {2'b00, opnd};
      acc_n = (mode == DIV) ? (trial[WIDTH+1] ? sh[WIDTH:0] : trial[WIDTH:0]) : {1'b0, sum[WIDTH:1]};
      low_n = (mode == DIV) ? {low[WIDTH-2:0], ~trial[WIDTH+1]} : {sum[0], low[WIDTH-1:1]};
   end
endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle MULTU/DIVU controller with HI/LO registers and pipeline stall
module muldiv_sequencer import muldiv_pkg::*; #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       ALUOp,
   input  logic [5:0]       function_field,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   output logic             stall,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] mf_data
);
   state_t state, state_n;
   logic [CNT_W-1:0] counter;
   logic [WIDTH:0] acc, acc_n;
   logic [WIDTH-1:0] low, low_n, opnd;
   logic rtype, is_mul, is_div, is_mf, accept;
   assign rtype = ALUOp == ALUOP_RTYPE;
   assign is_mul = rtype && function_field == MULTU;
   assign is_div = rtype && function_field == DIVU;
   assign is_mf = rtype && (function_field == MFHI || function_field == MFLO);
   assign accept = state == IDLE && start && (is_mul || is_div);
   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .mode(state), .acc(acc), .low(low), .opnd(opnd), .acc_n(acc_n), .low_n(low_n)
   );
   always_ff @(posedge clk)
      if (reset) state <= IDLE;
      else state <= state_n;
   always_comb begin
      state_n = state;
      if (state == IDLE) state_n = accept ? (is_mul ? MUL : (operand_b != '0 ? DIV : IDLE)) : IDLE;
      else if (counter == '0) state_n = IDLE;
   end
   always_comb begin
      busy = state != IDLE;
      stall = busy && start && (is_mul || is_div || is_mf);
      mf_data = (rtype && function_field == MFHI) ? hi : (rtype && function_field == MFLO) ? lo : '0;
   end
   // A zero divisor resolves at acceptance; the datapath is loaded but never iterated.
   always_ff @(posedge clk) begin
      if (reset) begin
         counter <= '0;
         acc <= '0;
         low <= '0;
         opnd <= '0;
         hi <= '0;
         lo <= '0;
         done <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         div_by_zero <= 1'b0;
         if (state == IDLE) begin
            if (accept) begin
               counter <= CNT_W'(WIDTH - 1);
               acc <= '0;
               opnd <= is_mul ? operand_a : operand_b;
               low <= is_mul ? operand_b : operand_a;
               if (is_div && operand_b == '0) begin
                  hi <= operand_a;
                  lo <= '1;
                  done <= 1'b1;
                  div_by_zero <= 1'b1;
               end
            end
         end else begin
            counter <= counter - 1'b1;
            acc <= acc_n;
            low <= low_n;
            if (counter == '0) begin
               hi <= acc_n[WIDTH-1:0];
               lo <= low_n;
               done <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed vectors for multiply, divide, divide-by-zero, stall and reset abort
module tb_muldiv_sequencer;
   import muldiv_pkg::*;
   logic clk = 1'b0, reset = 1'b1, start = 1'b0;
   logic [1:0] ALUOp = 2'b00;
   logic [5:0] function_field = 6'b0;
   logic [31:0] operand_a = '0, operand_b = '0;
   logic stall, busy, done, div_by_zero;
   logic [31:0] hi, lo, mf_data;
   int tests = 0, failures = 0;
   localparam logic [5:0] ADD = 6'b100000;
   muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
      .clk(clk), .reset(reset), .start(start), .ALUOp(ALUOp), .function_field(function_field),
      .operand_a(operand_a), .operand_b(operand_b), .stall(stall), .busy(busy), .done(done),
      .div_by_zero(div_by_zero), .hi(hi), .lo(lo), .mf_data(mf_data)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic issue(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
      start = 1'b1;
      ALUOp = ALUOP_RTYPE;
      function_field = fn;
      operand_a = a;
      operand_b = b;
      #1;
      check("stall_idle", 32'(stall), 0);
      tick;
      start = 1'b0;
   endtask
   task automatic run_op(input string tag, input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo, input logic exp_dbz, input int exp_cyc);
      int n;
      issue(fn, a, b);
      n = 0;
      while (busy && n < 40) begin
         n++;
         tick;
      end
      check({tag, "_cycles"}, n, exp_cyc);
      check({tag, "_done"}, 32'(done), 1);
      check({tag, "_dbz"}, 32'(div_by_zero), 32'(exp_dbz));
      check({tag, "_hi"}, hi, exp_hi);
      check({tag, "_lo"}, lo, exp_lo);
      tick;
      check({tag, "_done_clr"}, 32'(done), 0);
      check({tag, "_dbz_clr"}, 32'(div_by_zero), 0);
   endtask
   initial begin
      int n, s, d;
      tick;
      tick;
      reset = 1'b0;
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_dbz", 32'(div_by_zero), 0);
      check("rst_hi", hi, 0);
      check("rst_lo", lo, 0);
      run_op("mul7x6", MULTU, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0, 32);
      run_op("mulmax", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 32);
      run_op("div100_7", DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 32);
      run_op("div5_9", DIVU, 32'd5, 32'd9, 32'd5, 32'd0, 1'b0, 32);
      run_op("divzero", DIVU, 32'h1234, 32'd0, 32'h1234, 32'hFFFFFFFF, 1'b1, 0);
      ALUOp = ALUOP_RTYPE;
      function_field = ADD;
      start = 1'b1;
      tick;
      start = 1'b0;
      check("hold_hi", hi, 32'h1234);
      check("hold_lo", lo, 32'hFFFFFFFF);
      // MFLO held behind a running multiply, with one ADD slipped through mid-run
      issue(MULTU, 32'd3, 32'd5);
      start = 1'b1;
      function_field = MFLO;
      n = 0;
      s = 0;
      while (busy && n < 40) begin
         #1;
         s += int'(stall);
         if (n == 10) begin
            function_field = ADD;
            #1;
            check("add_nostall", 32'(stall), 0);
            function_field = MFLO;
         end
         n++;
         tick;
      end
      #1;
      check("mflo_stall_cycles", s, 32);
      check("mflo_stall_after", 32'(stall), 0);
      check("mflo_data", mf_data, 32'd15);
      function_field = MFHI;
      #1;
      check("mfhi_data", mf_data, 32'd0);
      start = 1'b0;
      tick;
      issue(MULTU, 32'd9, 32'd9);
      repeat (10) tick;
      reset = 1'b1;
      tick;
      reset = 1'b0;
      check("abort_busy", 32'(busy), 0);
      check("abort_hi", hi, 0);
      check("abort_lo", lo, 0);
      d = 0;
      repeat (40) begin
         d += int'(done);
         tick;
      end
      check("abort_no_done", d, 0);
      run_op("mul9x9", MULTU, 32'd9, 32'd9, 32'd0, 32'd81, 1'b0, 32);
      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end
endmodule
